// File: rtl/draw_obstacle_field_if.sv
// VGA stream bundle: timing counters, sync/blank flags and pixel colour.
interface vga_if;
    logic [11:0] hcount;
    logic [11:0] vcount;
    logic        hsync;
    logic        vsync;
    logic        hblnk;
    logic        vblnk;
    logic [11:0] rgb;

    modport in  (input  hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
    modport out (output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
endinterface

// File: rtl/draw_obstacle_field.sv
// Scrolling pillar-pair field overlaid on the VGA stream, 1-clock latency.
module draw_obstacle_field #(
    parameter int          N_OBST     = 3,
    parameter int          OBST_W     = 50,
    parameter int          GAP_H      = 150,
    parameter int          SPACING    = 250,
    parameter int          SPEED      = 2,
    parameter int          GAP_MIN    = 60,
    parameter int          GAP_MAX    = 330,
    parameter logic [11:0] COLOR      = 12'hff0,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1,
    parameter int          HOR_PIXELS = 800,
    parameter int          VER_PIXELS = 600
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        restart,
    input  logic [11:0] score_x,
    vga_if.in           in,
    vga_if.out          out,
    output logic        pass_pulse
);

    localparam logic [12:0] SPEED13  = 13'(SPEED);
    localparam logic [12:0] WRAP_ADD = 13'(N_OBST * SPACING - SPEED);
    localparam logic [8:0]  RANGE    = 9'(GAP_MAX - GAP_MIN);
    localparam logic [11:0] GAP_MID  = 12'((GAP_MIN + GAP_MAX) / 2);
    localparam logic [12:0] W13      = 13'(OBST_W);
    localparam logic [12:0] H13      = 13'(GAP_H);
    localparam logic [12:0] VMAX13   = 13'(VER_PIXELS);

    logic [12:0] r       [N_OBST];
    logic [11:0] gap_top [N_OBST];
    logic [12:0] r_nxt   [N_OBST];
    logic [11:0] gap_nxt [N_OBST];

    logic [15:0] lfsr;
    logic        lfsr_fb;
    logic        prev_vblnk;
    logic        tick;
    logic        pass_nxt;
    logic [8:0]  cand;
    logic [11:0] new_gap;
    logic [12:0] hc;
    logic [12:0] vc;
    logic [12:0] sx;
    logic        hit;
    logic [11:0] rgb_nxt;

    assign tick    = in.vblnk & ~prev_vblnk;
    assign lfsr_fb = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
    assign cand    = (lfsr[8:0] > RANGE) ? lfsr[8:0] - (RANGE + 9'd1)
                                         : lfsr[8:0];
    assign new_gap = 12'(GAP_MIN) + {3'b000, cand};
    assign hc      = {1'b0, in.hcount};
    assign vc      = {1'b0, in.vcount};
    assign sx      = {1'b0, score_x};

    // every wrapping obstacle on a tick shares the same LFSR sample
    always_comb begin
        pass_nxt = 1'b0;
        for (int i = 0; i < N_OBST; i++) begin
            r_nxt[i]   = r[i] - SPEED13;
            gap_nxt[i] = gap_top[i];
            if (r[i] <= SPEED13) begin
                r_nxt[i]   = r[i] + WRAP_ADD;
                gap_nxt[i] = new_gap;
            end else if (r[i] > sx && r_nxt[i] <= sx) begin
                pass_nxt = 1'b1;
            end
        end
    end

    always_comb begin
        hit = 1'b0;
        for (int i = 0; i < N_OBST; i++) begin
            if (hc < r[i] && hc + W13 >= r[i] &&
                (vc < {1'b0, gap_top[i]} ||
                 (vc >= {1'b0, gap_top[i]} + H13 && vc < VMAX13)))
                hit = 1'b1;
        end
        rgb_nxt = in.rgb;
        if (in.hblnk || in.vblnk)
            rgb_nxt = 12'h000;
        else if (hit)
            rgb_nxt = COLOR;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr       <= LFSR_SEED;
            prev_vblnk <= 1'b0;
        end else begin
            lfsr       <= {lfsr[14:0], lfsr_fb};
            prev_vblnk <= in.vblnk;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out.hcount <= '0;
            out.vcount <= '0;
            out.hsync  <= 1'b0;
            out.vsync  <= 1'b0;
            out.hblnk  <= 1'b0;
            out.vblnk  <= 1'b0;
            out.rgb    <= '0;
        end else begin
            out.hcount <= in.hcount;
            out.vcount <= in.vcount;
            out.hsync  <= in.hsync;
            out.vsync  <= in.vsync;
            out.hblnk  <= in.hblnk;
            out.vblnk  <= in.vblnk;
            out.rgb    <= rgb_nxt;
        end
    end

    // obstacle state only moves at vblank start, so frames never tear
    always_ff @(posedge clk) begin
        if (rst || restart) begin
            pass_pulse <= 1'b0;
            for (int i = 0; i < N_OBST; i++) begin
                r[i]       <= 13'(HOR_PIXELS + OBST_W + i * SPACING);
                gap_top[i] <= GAP_MID;
            end
        end else begin
            pass_pulse <= 1'b0;
            if (tick && enable) begin
                pass_pulse <= pass_nxt;
                for (int i = 0; i < N_OBST; i++) begin
                    r[i]       <= r_nxt[i];
                    gap_top[i] <= gap_nxt[i];
                end
            end
        end
    end

endmodule
